// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared MIPS pipeline constants and controller state type, used by the
// hazard controller and the pipeline registers it steers.
package mips_pipe_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    CTRL_RUN    = 1'b0,
    CTRL_MULDIV = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs from the pipeline and the
// stall/flush controls returned to it. master = pipeline side, slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  import mips_pipe_pkg::*;

  logic [REG_IDX_W-1:0]   id_rs;
  logic [REG_IDX_W-1:0]   id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic                   id_muldiv;
  logic [REG_IDX_W-1:0]   ex_writereg;
  logic                   ex_regwrite;
  logic                   ex_memread;
  logic [REG_IDX_W-1:0]   mem_writereg;
  logic                   mem_regwrite;
  logic                   ex_branch_taken;
  logic                   pc_write_en;
  logic                   ifid_write_en;
  logic                   ifid_flush;
  logic                   idex_bubble;
  logic                   idex_hold;
  logic                   muldiv_busy;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv,
    output ex_writereg, ex_regwrite, ex_memread,
    output mem_writereg, mem_regwrite, ex_branch_taken,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
    input  idex_hold, muldiv_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_muldiv,
    input  ex_writereg, ex_regwrite, ex_memread,
    input  mem_writereg, mem_regwrite, ex_branch_taken,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
    output idex_hold, muldiv_busy, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// One source/destination register comparator; $0 is hard-wired and never hazards.
module hazard_match
  import mips_pipe_pkg::*;
(
  input  logic                 uses,
  input  logic [REG_IDX_W-1:0] src,
  input  logic [REG_IDX_W-1:0] dst,
  input  logic                 regwrite,
  output logic                 match
);
  assign match = uses & regwrite & (src == dst) & (src != REG_ZERO);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline. Define FORWARDING_EN when
// the datapath has EX/MEM->EX forwarding (only load-use then stalls).
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LAT  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CNT_W = $clog2(MULDIV_LAT);
  localparam logic [0:0] RUN    = CTRL_RUN;
  localparam logic [0:0] MULDIV = CTRL_MULDIV;

  logic [0:0]             state;
  logic [CNT_W-1:0]       md_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   m_rs_ex, m_rt_ex, raw_stall, start_md;
  logic                   pc_we, ifid_we, flush, bubble, hold, busy;

  hazard_match u_rs_ex (.uses(hz.id_uses_rs), .src(hz.id_rs), .dst(hz.ex_writereg),
                        .regwrite(hz.ex_regwrite), .match(m_rs_ex));
  hazard_match u_rt_ex (.uses(hz.id_uses_rt), .src(hz.id_rt), .dst(hz.ex_writereg),
                        .regwrite(hz.ex_regwrite), .match(m_rt_ex));

`ifdef FORWARDING_EN
  assign raw_stall = (m_rs_ex | m_rt_ex) & hz.ex_memread;
`else
  logic m_rs_mem, m_rt_mem;
  hazard_match u_rs_mem (.uses(hz.id_uses_rs), .src(hz.id_rs), .dst(hz.mem_writereg),
                         .regwrite(hz.mem_regwrite), .match(m_rs_mem));
  hazard_match u_rt_mem (.uses(hz.id_uses_rt), .src(hz.id_rt), .dst(hz.mem_writereg),
                         .regwrite(hz.mem_regwrite), .match(m_rt_mem));
  // WB writes in the first half-cycle, so only EX and MEM destinations can hazard.
  assign raw_stall = m_rs_ex | m_rt_ex | m_rs_mem | m_rt_mem;
`endif

  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    hold     = 1'b0;
    busy     = 1'b0;
    start_md = 1'b0;
    if (reset) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      flush   = 1'b1;
      bubble  = 1'b1;
    end else if (state == MULDIV) begin
      // EX holds the multi-cycle op, so a branch cannot resolve here.
      busy    = 1'b1;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      hold    = 1'b1;
    end else if (hz.ex_branch_taken) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (raw_stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
    end else if (hz.id_muldiv) begin
      start_md = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      md_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (state == MULDIV) begin
        md_cnt <= md_cnt - CNT_W'(1);
        if (md_cnt == CNT_W'(1)) state <= RUN;
      end else if (start_md) begin
        state  <= MULDIV;
        md_cnt <= CNT_W'(MULDIV_LAT - 1);
      end
    end
  end

  assign hz.pc_write_en   = pc_we;
  assign hz.ifid_write_en = ifid_we;
  assign hz.ifid_flush    = flush;
  assign hz.idex_bubble   = bubble;
  assign hz.idex_hold     = hold;
  assign hz.muldiv_busy   = busy;
  assign hz.stall_count   = stall_cnt;
endmodule
